// File: rtl/pllcfg_pkg.sv
// Shared types and constants for the PLL-configuration command mailbox.
package pllcfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_POSTED   = 2'd1,
        ST_COMPLETE = 2'd2
    } pllcfg_state_t;

    localparam logic [1:0] ADDR_CMD   = 2'd0;
    localparam logic [1:0] ADDR_STAT  = 2'd1;
    localparam logic [1:0] ADDR_IRQEN = 2'd2;
    localparam logic [1:0] ADDR_TOCNT = 2'd3;

    localparam logic [3:0] CMD_NOP = 4'd0;

endpackage

// File: rtl/pllcfg_timeout_ctr.sv
// Loadable down-counter; expired_o strobes while enabled and the count sits at zero.
module pllcfg_timeout_ctr #(
    parameter int unsigned W = 24
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load has priority, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == {W{1'b0}});

endmodule

// File: rtl/pllcfg_cmd_mailbox.sv
// Fabric-to-Nios command mailbox: posts a 4-bit command, raises irq, and waits
// for the CPU completion write or a timeout before returning done/error.
module pllcfg_cmd_mailbox
    import pllcfg_pkg::*;
#(
    parameter int unsigned          TO_W        = 24,
    parameter logic [TO_W-1:0]      TIMEOUT_CYC = 24'd10_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_req,
    input  logic [3:0]  cmd_code,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic        cmd_err,
    output logic [3:0]  cmd_port,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        irq
);

    pllcfg_state_t state_q, state_d;
    logic [3:0]    code_q, code_d;
    logic          err_q, err_d;
    logic          irq_en_q, irq_en_d;
    logic [15:0]   tocnt_q, tocnt_d;

    logic          busy_q, done_q, irq_q;
    logic [3:0]    port_q;
    logic [31:0]   rdata_q;
    logic [31:0]   rdata_s;

    logic          pending_s;
    logic          stat_wr_s;
    logic          load_s;
    logic          expired_s;
    logic          unused_s;

    assign pending_s = (state_q == ST_POSTED);
    assign stat_wr_s = write && (address == ADDR_STAT) && writedata[0];
    assign unused_s  = ^writedata[31:2];

    pllcfg_timeout_ctr #(
        .W (TO_W)
    ) u_timeout_ctr (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (load_s),
        .load_val_i (TIMEOUT_CYC),
        .en_i       (pending_s),
        .expired_o  (expired_s)
    );

    // Command FSM and register-file next state; a CPU completion beats expiry.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        err_d    = err_q;
        irq_en_d = irq_en_q;
        tocnt_d  = tocnt_q;
        load_s   = 1'b0;

        if (write && (address == ADDR_IRQEN)) begin
            irq_en_d = writedata[0];
        end else begin
            irq_en_d = irq_en_q;
        end

        if (write && (address == ADDR_TOCNT)) begin
            tocnt_d = 16'd0;
        end else begin
            tocnt_d = tocnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_req && (cmd_code != CMD_NOP)) begin
                    code_d  = cmd_code;
                    err_d   = 1'b0;
                    load_s  = 1'b1;
                    state_d = ST_POSTED;
                end else if (cmd_req) begin
                    err_d   = 1'b1;
                    state_d = ST_COMPLETE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_POSTED: begin
                if (stat_wr_s) begin
                    err_d   = writedata[1];
                    state_d = ST_COMPLETE;
                end else if (expired_s) begin
                    err_d   = 1'b1;
                    tocnt_d = (tocnt_q == 16'hFFFF) ? tocnt_q : tocnt_q + 16'd1;
                    state_d = ST_COMPLETE;
                end else begin
                    state_d = ST_POSTED;
                end
            end
            ST_COMPLETE: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Read mux, sampled into readdata on the read edge.
    always_comb begin
        rdata_s = 32'd0;
        case (address)
            ADDR_CMD:   rdata_s = {27'd0, pending_s, code_q};
            ADDR_STAT:  rdata_s = 32'd0;
            ADDR_IRQEN: rdata_s = {31'd0, irq_en_q};
            ADDR_TOCNT: rdata_s = {16'd0, tocnt_q};
            default:    rdata_s = 32'd0;
        endcase
    end

    // State, registers and registered outputs; reset drops any command in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            code_q   <= 4'd0;
            err_q    <= 1'b0;
            irq_en_q <= 1'b0;
            tocnt_q  <= 16'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            port_q   <= 4'd0;
            irq_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            err_q    <= err_d;
            irq_en_q <= irq_en_d;
            tocnt_q  <= tocnt_d;
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= (state_d == ST_COMPLETE);
            port_q   <= (state_d == ST_POSTED) ? code_d : 4'd0;
            irq_q    <= pending_s && irq_en_q;
            rdata_q  <= read ? rdata_s : 32'd0;
        end
    end

    assign cmd_busy = busy_q;
    assign cmd_done = done_q;
    assign cmd_err  = err_q;
    assign cmd_port = port_q;
    assign irq      = irq_q;
    assign readdata = rdata_q;

endmodule

// File: tb/tb_pllcfg_cmd_mailbox.sv
// Self-checking bench: directed scenarios plus random traffic against a
// deadline-based transaction model of the mailbox.
module tb_pllcfg_cmd_mailbox;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_req;
    logic [3:0]  cmd_code;
    logic        cmd_busy, cmd_done, cmd_err, irq;
    logic [3:0]  cmd_port;
    logic [1:0]  address;
    logic        write, read;
    logic [31:0] writedata, readdata;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // reference model: idle / posted-with-deadline / completing
    bit          m_posted, m_complete, m_err, m_irq_en, m_irq;
    logic [3:0]  m_code;
    int          m_tocnt;
    int          m_deadline;
    logic [31:0] m_rdata;

    pllcfg_cmd_mailbox #(.TO_W(24), .TIMEOUT_CYC(24'd8)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_req(cmd_req), .cmd_code(cmd_code),
        .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .cmd_port(cmd_port), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_posted = 0; m_complete = 0; m_err = 0; m_irq_en = 0; m_irq = 0;
        m_code = 4'd0; m_tocnt = 0; m_deadline = 0; m_rdata = 32'd0;
    endtask

    task automatic model_edge();
        bit          was_posted;
        bit          was_irq_en;
        logic [31:0] rv;
        was_posted = m_posted;
        was_irq_en = m_irq_en;
        case (address)
            2'd0:    rv = {27'd0, m_posted, m_code};
            2'd2:    rv = {31'd0, m_irq_en};
            2'd3:    rv = 32'(m_tocnt);
            default: rv = 32'd0;
        endcase
        m_rdata = read ? rv : 32'd0;
        if (write && address == 2'd3) m_tocnt = 0;
        if (write && address == 2'd2) m_irq_en = writedata[0];
        if (m_complete) begin
            m_complete = 0;
        end else if (!m_posted) begin
            if (cmd_req && cmd_code != 4'd0) begin
                m_posted = 1; m_code = cmd_code; m_err = 0; m_deadline = cyc + T + 1;
            end else if (cmd_req) begin
                m_complete = 1; m_err = 1;
            end
        end else if (write && address == 2'd1 && writedata[0]) begin
            m_posted = 0; m_complete = 1; m_err = writedata[1];
        end else if (cyc == m_deadline) begin
            m_posted = 0; m_complete = 1; m_err = 1;
            if (m_tocnt < 65535) m_tocnt++;
        end
        m_irq = was_posted && was_irq_en;
    endtask

    task automatic compare_all();
        chk("busy", 32'(cmd_busy), 32'(m_posted || m_complete));
        chk("done", 32'(cmd_done), 32'(m_complete));
        chk("err",  32'(cmd_err),  32'(m_err));
        chk("port", 32'(cmd_port), m_posted ? 32'(m_code) : 32'd0);
        chk("irq",  32'(irq),      32'(m_irq));
        chk("rdata", readdata,     m_rdata);
    endtask

    task automatic idle_in();
        cmd_req = 1'b0; cmd_code = 4'd0; address = 2'd0;
        write = 1'b0; writedata = 32'd0; read = 1'b0;
    endtask

    task automatic step();
        cyc++;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        idle_in();
    endtask

    task automatic req(input logic [3:0] code);
        cmd_req = 1'b1; cmd_code = code; step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; write = 1'b1; writedata = d; step();
    endtask

    task automatic rd(input logic [1:0] a);
        address = a; read = 1'b1; step();
    endtask

    initial begin
        idle_in();
        model_reset();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        compare_all();
        reset_n = 1'b1;

        // normal command with irq enabled
        wr(2'd2, 32'h1);
        req(4'h5);
        chk("dir_port5", 32'(cmd_port), 32'h5);
        step();
        chk("dir_irq_up", 32'(irq), 32'h1);
        rd(2'd0);
        chk("dir_rd_cmd", readdata, 32'h15);
        wr(2'd1, 32'h1);
        chk("dir_done_ok", {cmd_done, cmd_err, cmd_port}, {1'b1, 1'b0, 4'h0});
        step();
        chk("dir_irq_down", 32'(irq), 32'h0);

        // CPU-reported error, held until next acceptance
        req(4'h9);
        step();
        wr(2'd1, 32'h3);
        chk("dir_done_err", {cmd_done, cmd_err}, 2'b11);
        step(); step(); step();
        chk("dir_err_hold", 32'(cmd_err), 32'h1);

        // timeout: done with err exactly T+1 edges after acceptance
        req(4'h3);
        chk("dir_err_clr", 32'(cmd_err), 32'h0);
        for (int i = 0; i < T; i++) step();
        chk("dir_to_early", 32'(cmd_done), 32'h0);
        step();
        chk("dir_to_done", {cmd_done, cmd_err}, 2'b11);
        step();
        rd(2'd3);
        chk("dir_tocnt1", readdata, 32'h1);
        wr(2'd3, 32'hDEAD_BEEF);
        rd(2'd3);
        chk("dir_tocnt0", readdata, 32'h0);

        // NOP rejection
        req(4'h0);
        chk("dir_nop", {cmd_done, cmd_err, irq}, 3'b110);
        step();
        chk("dir_nop_irq", 32'(irq), 32'h0);

        // CPU write on the expiry edge wins
        req(4'h6);
        for (int i = 0; i < T; i++) step();
        wr(2'd1, 32'h1);
        chk("dir_coll", {cmd_done, cmd_err}, 2'b10);
        step();
        rd(2'd3);
        chk("dir_coll_tocnt", readdata, 32'h0);

        // request while busy is ignored; status write in IDLE has no effect
        req(4'h7);
        req(4'h2);
        chk("dir_busy_req", 32'(cmd_port), 32'h7);
        wr(2'd1, 32'h1);
        step();
        wr(2'd1, 32'h1);
        chk("dir_idle_wr", 32'(cmd_done), 32'h0);

        // asynchronous reset while POSTED
        req(4'h4);
        step();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("dir_rst", {cmd_busy, cmd_done, cmd_err, cmd_port, irq}, 8'h00);
        chk("dir_rst_rd", readdata, 32'h0);
        @(negedge clk);
        compare_all();
        reset_n = 1'b1;
        req(4'hA);
        chk("dir_post_rst", 32'(cmd_port), 32'hA);

        // random traffic (timeout counter writes are issued only by directed code)
        for (int i = 0; i < 600; i++) begin
            cmd_req  = ($urandom_range(2, 0) == 0);
            cmd_code = 4'($urandom_range(15, 0));
            read     = $urandom_range(1, 0) == 1;
            write    = ($urandom_range(3, 0) == 0);
            address  = write ? 2'($urandom_range(2, 0)) : 2'($urandom_range(3, 0));
            writedata = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
